// File: rtl/serial_full_adder_nand.sv
// Bit-serial WIDTH-bit adder: one NAND-only full-adder cell, LSB first, one bit per clock.
// A carry flop chains the bits; an IDLE/ADD/DONE FSM sequences load, shift and done.

module serial_full_adder_nand_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_n1, w_n2, w_n3, w_x;
    logic w_m1, w_m2, w_m3;

    // a ^ b from four NANDs; w_n1 = ~(a & b) is reused for the carry merge
    nand g_n1 (w_n1, i_a, i_b);
    nand g_n2 (w_n2, i_a, w_n1);
    nand g_n3 (w_n3, i_b, w_n1);
    nand g_x  (w_x,  w_n2, w_n3);

    nand g_m1 (w_m1, w_x, i_c);
    nand g_m2 (w_m2, w_x, w_m1);
    nand g_m3 (w_m3, i_c, w_m1);
    nand g_s  (o_s,  w_m2, w_m3);

    // carry = (a & b) | ((a ^ b) & c)
    nand g_c  (o_c,  w_n1, w_m1);
endmodule

module serial_full_adder_nand #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'((WIDTH > 1) ? WIDTH - 2 : 0);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_c_msb_in;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic             w_s_bit;
    logic             w_c_bit;

    serial_full_adder_nand_cell u_cell (
        .i_a (r_a_sh[0]),
        .i_b (b_bit0()),
        .i_c (r_carry),
        .o_s (w_s_bit),
        .o_c (w_c_bit)
    );

    function automatic logic b_bit0();
        return r_b_sh[0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_sum      <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_c_msb_in <= 1'b0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh     <= a;
                        r_b_sh     <= b;
                        r_carry    <= cin;
                        // covers WIDTH==1, where the loaded carry is the carry into the MSB
                        r_c_msb_in <= cin;
                        r_cnt      <= '0;
                        r_sum      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_sum   <= (r_sum >> 1) | (WIDTH'(w_s_bit) << (WIDTH - 1));
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_c_bit;
                    r_cnt   <= r_cnt + CW'(1);
                    if ((WIDTH > 1) && (r_cnt == PENULT))
                        r_c_msb_in <= w_c_bit;
                    if (r_cnt == LAST) begin
                        r_cout  <= w_c_bit;
                        r_ovf   <= r_c_msb_in ^ w_c_bit;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
endmodule

// File: doc/serial_full_adder_nand.md
Name: serial_full_adder_nand

Overview:
- Bit-serial N-bit adder, the addition counterpart of the team's NAND full subtractor.
- One full-adder bit cell built only from 2-input nand primitives computes one bit per clock, LSB first.
- A carry flip-flop chains the bits, and a small FSM sequences load, shift and done.
- Used as the area-minimal adder in the gate-level arithmetic datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  augend; captured on the accepted start.
- b  input  WIDTH  addend; captured on the accepted start.
- cin  input  1  carry-in; captured on the accepted start.
- busy  output  1  high while in ADD or DONE.
- done  output  1  one-cycle pulse; sum/cout/ovf valid.
- sum  output  WIDTH  registered result; held until the next accepted start.
- cout  output  1  registered final carry.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy, done, sum, cout, ovf, carry flop, bit counter and shift registers all 0. Reset overrides everything, including a transfer in ADD.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - On start=1: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum<=0; go to ADD.
  - On start=0: stay in IDLE. Outputs hold their last values.
- ADD (one bit per cycle):
  - The bit cell takes a_sh[0], b_sh[0] and carry.
  - The cell is exactly 9 nand instances (XOR-by-4-NAND twice plus carry merge); no behavioural + or ^ in the cell.
  - Each edge: sum <= {s_bit, sum[WIDTH-1:1]}; a_sh and b_sh shift right with 0 fill; carry <= c_bit; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-2, latch c_msb_in <= c_bit (carry into MSB). When WIDTH==1, c_msb_in = the loaded cin.
  - On the edge where cnt==WIDTH-1: cout <= c_bit; ovf <= c_msb_in ^ c_bit; go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally. start is ignored in DONE.
- Latency: start accepted at edge E0. Bits are computed on edges E1..E_WIDTH. done is high in the cycle following E_WIDTH. Total WIDTH+1 cycles from acceptance to done. Back-to-back throughput is one operation per WIDTH+2 cycles.
- start is ignored while busy=1. Inputs a, b and cin may change freely after acceptance.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.
- Outputs are registered only, so there is no combinational path from the inputs to sum, cout, ovf, done or busy.
- Counter width is $clog2(WIDTH+1). It never exceeds WIDTH-1 in ADD.
- Reset asserted in the same cycle as start: reset wins and the start is lost.

Test Plan:
- WIDTH=8, a=8'h3C, b=8'h0F, cin=0, start for 1 cycle -> done exactly 9 cycles after the start edge; sum=8'h4B, cout=0, ovf=0; busy high for 9 cycles.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
- a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1, ovf=0.
- Start 3C+0F, pulse start again with a=8'h11 at cycles 3 and 9 (DONE) -> both ignored; result 8'h4B; a new start in the following IDLE cycle is accepted.
- Assert rst for 1 cycle at cycle 4 of an add -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0, state IDLE. A fresh 8'h05+8'h03 then yields 8'h08.
- WIDTH=1 and WIDTH=4 builds: exhaustive a, b, cin compared against a reference sum for sum, cout and ovf. Check done latency of WIDTH+1 for every operation.
